// File: rtl/param_instcache.sv
// param_instcache: parametrised direct-mapped instruction cache with a
// two-state fill FSM, flush input and a stall output for the fetch port.
// Hits return the addressed word combinationally in the same cycle; a miss
// stalls the CPU and fetches one whole line from instruction memory.
// Optional feature macro: ICACHE_STATS_EN adds saturating 16-bit
// hit_count / miss_count outputs.
module param_instcache #(
  parameter int ADDR_W   = 10,
  parameter int INDEX_W  = 3,
  parameter int OFFSET_W = 2,
  localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W - 2,
  localparam int LINE_W  = 32 * (2 ** OFFSET_W),
  localparam int MA_W    = ADDR_W - OFFSET_W - 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic              flush,
  output logic [31:0]       instruction,
  output logic              busywait,
  output logic              mem_read,
  output logic [MA_W-1:0]   mem_address,
  input  logic [LINE_W-1:0] mem_readdata,
`ifdef ICACHE_STATS_EN
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count,
`endif
  input  logic              mem_busywait
);

  localparam int LINES = 2 ** INDEX_W;
  localparam int WORDS = 2 ** OFFSET_W;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MEM_READ = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [MA_W-1:0]     mem_addr_q, mem_addr_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [LINE_W-1:0]   data_q [LINES];
  logic                just_filled_q;

  logic [TAG_W-1:0]    cpu_tag;
  logic [INDEX_W-1:0]  cpu_index;
  logic [OFFSET_W-1:0] cpu_word;
  logic [INDEX_W-1:0]  fill_index;
  logic [TAG_W-1:0]    fill_tag;
  logic                hit;
  logic                fill_en;
  logic [31:0]         sel_word;
  logic                unused_byte_bits;

  // Address split; byte-in-word bits are never used by an instruction fetch.
  assign cpu_tag          = address[ADDR_W-1 -: TAG_W];
  assign cpu_index        = address[ADDR_W-TAG_W-1 -: INDEX_W];
  assign cpu_word         = address[OFFSET_W+1 : 2];
  assign unused_byte_bits = ^address[1:0];

  // The fill always targets the line latched on the miss edge, not the
  // live CPU address, which may wander during the stall.
  assign fill_index = mem_addr_q[INDEX_W-1:0];
  assign fill_tag   = mem_addr_q[MA_W-1 -: TAG_W];

  assign hit     = valid_q[cpu_index] && (tag_q[cpu_index] == cpu_tag);
  assign fill_en = (state_q == MEM_READ) && !mem_busywait && !reset;

  // Select the addressed word out of the indexed line.
  always_comb begin
    sel_word = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (cpu_word == w[OFFSET_W-1:0]) sel_word = data_q[cpu_index][w*32 +: 32];
    end
  end

  // Fetch-port outputs: stall unless an IDLE hit, word only on an IDLE hit.
  always_comb begin
    busywait    = 1'b0;
    instruction = '0;
    if (!reset) busywait = read && !((state_q == IDLE) && hit);
    if ((state_q == IDLE) && hit) instruction = sel_word;
  end

  assign mem_read    = (state_q == MEM_READ);
  assign mem_address = mem_addr_q;

  // Next-state logic for the FSM, line address latch and valid bits.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    valid_d    = valid_q;
    case (state_q)
      IDLE: begin
        if (read && !hit) begin
          state_d    = MEM_READ;
          mem_addr_d = {cpu_tag, cpu_index};
        end
      end
      MEM_READ: begin
        if (!mem_busywait) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flush wipes every line, but a line landing on the same edge survives.
    if (flush)   valid_d = '0;
    if (fill_en) valid_d[fill_index] = 1'b1;
  end

  // FSM and control registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      mem_addr_q    <= '0;
      valid_q       <= '0;
      just_filled_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_addr_q    <= mem_addr_d;
      valid_q       <= valid_d;
      just_filled_q <= fill_en;
    end
  end

  // Tag and data arrays; contents are meaningless until the valid bit is set.
  always_ff @(posedge clock) begin
    if (fill_en) begin
      tag_q[fill_index]  <= fill_tag;
      data_q[fill_index] <= mem_readdata;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count_q, miss_count_q;

  // Saturating counters; the hit that completes a fill is not a real hit.
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if ((state_q == IDLE) && read && hit && !just_filled_q && (hit_count_q != 16'hFFFF))
        hit_count_q <= hit_count_q + 16'd1;
      if ((state_q == IDLE) && (state_d == MEM_READ) && (miss_count_q != 16'hFFFF))
        miss_count_q <= miss_count_q + 16'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  logic unused_just_filled;
  assign unused_just_filled = just_filled_q;
`endif

endmodule

// File: tb/tb_param_instcache.sv
// Directed bench for param_instcache with default parameters and a simple
// line memory that answers five busy cycles after mem_read rises.
module tb_param_instcache;

  localparam int ADDR_W = 10;
  localparam int LAT    = 5;

  logic         clock = 1'b0;
  logic         reset, read, flush;
  logic [9:0]   address;
  logic [31:0]  instruction;
  logic         busywait, mem_read, mem_busywait;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
`ifdef ICACHE_STATS_EN
  logic [15:0]  hit_count, miss_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int k;

  always #5 clock = ~clock;

  param_instcache #(.ADDR_W(10), .INDEX_W(3), .OFFSET_W(2)) dut (
    .clock(clock),
    .reset(reset),
    .read(read),
    .address(address),
    .flush(flush),
    .instruction(instruction),
    .busywait(busywait),
    .mem_read(mem_read),
    .mem_address(mem_address),
    .mem_readdata(mem_readdata),
`ifdef ICACHE_STATS_EN
    .hit_count(hit_count),
    .miss_count(miss_count),
`endif
    .mem_busywait(mem_busywait)
  );

  // Memory content: each word encodes its line address and word number.
  function automatic logic [31:0] mem_word(input logic [5:0] la, input logic [1:0] w);
    return {8'hA5, 10'd0, la, 6'd0, w};
  endfunction

  function automatic logic [31:0] exp_word(input logic [9:0] a);
    return mem_word(a[9:4], a[3:2]);
  endfunction

  // Memory model: busy for LAT cycles of mem_read, then data ready.
  logic [3:0] mem_cnt;
  always @(posedge clock) begin
    if (reset || !mem_read) mem_cnt <= 4'd0;
    else if (mem_busywait)  mem_cnt <= mem_cnt + 4'd1;
  end
  assign mem_busywait = mem_read && (mem_cnt < LAT);
  assign mem_readdata = {mem_word(mem_address, 2'd3), mem_word(mem_address, 2'd2),
                         mem_word(mem_address, 2'd1), mem_word(mem_address, 2'd0)};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Fetch one address, counting stall cycles; also watches mem_read/mem_address.
  task automatic fetch(input string tag, input logic [9:0] a, input int exp_stall);
    int stall;
    read    = 1'b1;
    address = a;
    stall   = 0;
    @(negedge clock);
    check({tag, "_busy0"}, {31'd0, busywait}, {31'd0, exp_stall != 0});
    while (busywait && stall < 40) begin
      check({tag, "_mrd"}, {31'd0, mem_read}, {31'd0, stall != 0});
      if (mem_read) check({tag, "_maddr"}, {26'd0, mem_address}, {26'd0, a[9:4]});
      stall++;
      step();
      @(negedge clock);
    end
    check({tag, "_stall"}, stall, exp_stall);
    check({tag, "_instr"}, instruction, exp_word(a));
    step();
    read = 1'b0;
  endtask

  initial begin
    reset = 1'b1; read = 1'b0; flush = 1'b0; address = '0;
    repeat (2) step();
    read = 1'b1;
    @(negedge clock);
    check("rst_busy",  {31'd0, busywait}, 32'd0);
    check("rst_mrd",   {31'd0, mem_read}, 32'd0);
    check("rst_maddr", {26'd0, mem_address}, 32'd0);
    check("rst_instr", instruction, 32'd0);
    step();
    reset = 1'b0;

    // Cold miss then same-line hits.
    fetch("m000", 10'h000, LAT + 2);
    fetch("h004", 10'h004, 0);
    fetch("h008", 10'h008, 0);
    fetch("h00c", 10'h00C, 0);

    // Conflict on index 0.
    fetch("c080", 10'h080, LAT + 2);
    check("c080_la", {26'd0, mem_address}, 32'h08);
    fetch("c000", 10'h000, LAT + 2);

    // Flush pulse invalidates line 0.
    flush = 1'b1;
    step();
    flush = 1'b0;
    fetch("f000", 10'h000, LAT + 2);

    // Flush on the fill edge: only the filled line remains valid.
    fetch("m010", 10'h010, LAT + 2);
    read = 1'b1; address = 10'h080; k = 0;
    @(negedge clock);
    while (!(mem_read && !mem_busywait) && k < 40) begin
      k++;
      step();
      @(negedge clock);
    end
    check("ff_wait", {31'd0, k < 40}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clock);
    check("ff_busy",  {31'd0, busywait}, 32'd0);
    check("ff_instr", instruction, exp_word(10'h080));
    step();
    read = 1'b0;
    fetch("ff084", 10'h084, 0);
    fetch("ff010", 10'h010, LAT + 2);

    // Reset in the middle of MEM_READ.
    read = 1'b1; address = 10'h020;
    step();
    step();
    @(negedge clock);
    check("rm_mrd1", {31'd0, mem_read}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("rm_busy", {31'd0, busywait}, 32'd0);
    step();
    reset = 1'b0; read = 1'b0;
    @(negedge clock);
    check("rm_mrd0", {31'd0, mem_read}, 32'd0);
    step();
    fetch("rm020", 10'h020, LAT + 2);

`ifdef ICACHE_STATS_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    check("st_hit0",  {16'd0, hit_count},  32'd0);
    check("st_miss0", {16'd0, miss_count}, 32'd0);
    step();
    fetch("s000", 10'h000, LAT + 2);
    fetch("s004", 10'h004, 0);
    fetch("s000b", 10'h000, 0);
    fetch("s080", 10'h080, LAT + 2);
    @(negedge clock);
    check("st_hit2",  {16'd0, hit_count},  32'd2);
    check("st_miss2", {16'd0, miss_count}, 32'd2);
    step();
    read = 1'b1; address = 10'h084;
    repeat (70000) step();
    read = 1'b0;
    @(negedge clock);
    check("st_hsat",  {16'd0, hit_count},  32'h0000FFFF);
    check("st_msat",  {16'd0, miss_count}, 32'd2);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clock);
    check("st_hflush", {16'd0, hit_count},  32'h0000FFFF);
    check("st_mflush", {16'd0, miss_count}, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
